gpu_ring_stop: RTL and testbench

- Network stop placed directly downstream of each GPU's 16-bit network port, between the GPU and the inter-GPU ring link.
- Buffers flits the GPU injects and merges them onto the ring with the pass-through traffic.
- Ejects ring flits addressed to this node back to the GPU and forwards all other flits.
- Flit format is {dest[15:10], payload[9:0]}.

---
 rtl/gpu_ring_stop.sv | 171 +++++++++++++++++
 tb/tb_gpu_ring_stop.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_ring_stop.sv
// Per-GPU ring network stop: buffers GPU injections and upstream ring flits,
// ejects flits addressed to this node and merges everything else onto the ring.
module gpu_ring_stop #(
    parameter int unsigned NODE_ID    = 7,
    parameter int unsigned INJ_DEPTH  = 4,
    parameter int unsigned PASS_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [15:0]                inj_data,
    input  logic                       inj_valid,
    output logic                       inj_ready,
    output logic [15:0]                ej_data,
    output logic                       ej_valid,
    input  logic                       ej_ready,
    input  logic [15:0]                ring_in_data,
    input  logic                       ring_in_valid,
    output logic                       ring_in_ready,
    output logic [15:0]                ring_out_data,
    output logic                       ring_out_valid,
    input  logic                       ring_out_ready,
    output logic [$clog2(INJ_DEPTH):0] inj_level,
    output logic [15:0]                ej_count
);

    localparam int unsigned IAW = $clog2(INJ_DEPTH);
    localparam int unsigned PAW = $clog2(PASS_DEPTH);
    localparam int unsigned SW  = $clog2(STARVE_MAX + 1);

    localparam logic [5:0]    NODE       = 6'(NODE_ID);
    localparam logic [IAW:0]  INJ_FULL   = (IAW + 1)'(INJ_DEPTH);
    localparam logic [PAW:0]  PASS_FULL  = (PAW + 1)'(PASS_DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [15:0]    inj_mem  [INJ_DEPTH];
    logic [15:0]    pass_mem [PASS_DEPTH];

    logic [IAW-1:0] inj_wr_q, inj_wr_d, inj_rd_q, inj_rd_d;
    logic [IAW:0]   inj_cnt_q, inj_cnt_d;
    logic [PAW-1:0] pass_wr_q, pass_wr_d, pass_rd_q, pass_rd_d;
    logic [PAW:0]   pass_cnt_q, pass_cnt_d;

    logic           ro_valid_q, ro_valid_d;
    logic [15:0]    ro_data_q, ro_data_d;
    logic           ej_valid_q, ej_valid_d;
    logic [15:0]    ej_data_q, ej_data_d;
    logic [15:0]    ej_count_q, ej_count_d;
    logic [SW-1:0]  starve_q, starve_d;

    logic           inj_push, inj_pop, pass_push, pass_pop;
    logic [15:0]    inj_head, pass_head;
    logic           inj_to_ej, inj_to_ring, pass_to_ej, pass_to_ring;
    logic           ro_open, ej_open, inj_forced;
    logic           ro_take_inj, ro_take_pass, ej_take_inj, ej_take_pass;

    // Readies are held low for the whole reset cycle so no flit slips in.
    assign inj_ready     = !ARESET && (inj_cnt_q != INJ_FULL);
    assign ring_in_ready = !ARESET && (pass_cnt_q != PASS_FULL);
    assign inj_push      = inj_valid && inj_ready;
    assign pass_push     = ring_in_valid && ring_in_ready;

    assign inj_head      = inj_mem[inj_rd_q];
    assign pass_head     = pass_mem[pass_rd_q];
    assign inj_to_ej     = (inj_cnt_q != '0) && (inj_head[15:10] == NODE);
    assign inj_to_ring   = (inj_cnt_q != '0) && (inj_head[15:10] != NODE);
    assign pass_to_ej    = (pass_cnt_q != '0) && (pass_head[15:10] == NODE);
    assign pass_to_ring  = (pass_cnt_q != '0) && (pass_head[15:10] != NODE);

    assign ro_open       = !ro_valid_q || ring_out_ready;
    assign ej_open       = !ej_valid_q || ej_ready;

    // Pass traffic normally owns the ring; a starved injector takes one slot.
    assign inj_forced    = inj_to_ring && (starve_q == STARVE_LIM);
    assign ro_take_inj   = ro_open && inj_to_ring && (inj_forced || !pass_to_ring);
    assign ro_take_pass  = ro_open && pass_to_ring && !inj_forced;
    assign ej_take_pass  = ej_open && pass_to_ej;
    assign ej_take_inj   = ej_open && inj_to_ej && !pass_to_ej;

    assign inj_pop       = ro_take_inj || ej_take_inj;
    assign pass_pop      = ro_take_pass || ej_take_pass;

    assign ring_out_valid = ro_valid_q;
    assign ring_out_data  = ro_data_q;
    assign ej_valid       = ej_valid_q;
    assign ej_data        = ej_data_q;
    assign ej_count       = ej_count_q;
    assign inj_level      = inj_cnt_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        inj_wr_d   = inj_wr_q;
        inj_rd_d   = inj_rd_q;
        pass_wr_d  = pass_wr_q;
        pass_rd_d  = pass_rd_q;
        ro_data_d  = ro_data_q;
        ej_data_d  = ej_data_q;
        ej_count_d = ej_count_q;
        starve_d   = starve_q;
        ro_valid_d = ro_valid_q && !ring_out_ready;
        ej_valid_d = ej_valid_q && !ej_ready;

        if (inj_push)  inj_wr_d  = inj_wr_q + IAW'(1);
        if (inj_pop)   inj_rd_d  = inj_rd_q + IAW'(1);
        if (pass_push) pass_wr_d = pass_wr_q + PAW'(1);
        if (pass_pop)  pass_rd_d = pass_rd_q + PAW'(1);
        inj_cnt_d  = inj_cnt_q + (IAW + 1)'(inj_push) - (IAW + 1)'(inj_pop);
        pass_cnt_d = pass_cnt_q + (PAW + 1)'(pass_push) - (PAW + 1)'(pass_pop);

        if (ro_take_inj) begin
            ro_valid_d = 1'b1;
            ro_data_d  = inj_head;
        end else if (ro_take_pass) begin
            ro_valid_d = 1'b1;
            ro_data_d  = pass_head;
        end

        if (ej_take_pass || ej_take_inj) begin
            ej_valid_d = 1'b1;
            ej_data_d  = ej_take_pass ? pass_head : inj_head;
            ej_count_d = ej_count_q + 16'd1;
        end

        // Starvation only advances in cycles where ring_out could accept a flit.
        if (ro_open) begin
            if (!inj_to_ring || ro_take_inj) begin
                starve_d = '0;
            end else if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            inj_wr_q   <= '0;
            inj_rd_q   <= '0;
            inj_cnt_q  <= '0;
            pass_wr_q  <= '0;
            pass_rd_q  <= '0;
            pass_cnt_q <= '0;
            ro_valid_q <= 1'b0;
            ro_data_q  <= '0;
            ej_valid_q <= 1'b0;
            ej_data_q  <= '0;
            ej_count_q <= '0;
            starve_q   <= '0;
        end else begin
            inj_wr_q   <= inj_wr_d;
            inj_rd_q   <= inj_rd_d;
            inj_cnt_q  <= inj_cnt_d;
            pass_wr_q  <= pass_wr_d;
            pass_rd_q  <= pass_rd_d;
            pass_cnt_q <= pass_cnt_d;
            ro_valid_q <= ro_valid_d;
            ro_data_q  <= ro_data_d;
            ej_valid_q <= ej_valid_d;
            ej_data_q  <= ej_data_d;
            ej_count_q <= ej_count_d;
            starve_q   <= starve_d;
        end
    end

    // NOTE: FIFO storage has no reset; emptied pointers/counts make stale entries unreachable.
    always_ff @(posedge ACLK) begin
        if (inj_push)  inj_mem[inj_wr_q]   <= inj_data;
        if (pass_push) pass_mem[pass_wr_q] <= ring_in_data;
    end

endmodule

// File: tb/tb_gpu_ring_stop.sv
// Directed bench for gpu_ring_stop: a queue-based reference model is checked
// every cycle, and literal expectations pin latency, starvation and ordering.
module tb_gpu_ring_stop;

    localparam int unsigned NODE_ID    = 7;
    localparam int unsigned INJ_DEPTH  = 4;
    localparam int unsigned PASS_DEPTH = 2;
    localparam int unsigned STARVE_MAX = 8;

    logic        ACLK   = 1'b0;
    logic        ARESET = 1'b1;
    logic [15:0] inj_data, ej_data, ring_in_data, ring_out_data, ej_count;
    logic        inj_valid, inj_ready, ej_valid, ej_ready;
    logic        ring_in_valid, ring_in_ready, ring_out_valid, ring_out_ready;
    logic [2:0]  inj_level;

    gpu_ring_stop #(
        .NODE_ID(NODE_ID), .INJ_DEPTH(INJ_DEPTH),
        .PASS_DEPTH(PASS_DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .inj_data(inj_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
        .ej_data(ej_data), .ej_valid(ej_valid), .ej_ready(ej_ready),
        .ring_in_data(ring_in_data), .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready),
        .ring_out_data(ring_out_data), .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready),
        .inj_level(inj_level), .ej_count(ej_count)
    );

    initial forever #5 ACLK = ~ACLK;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } xfer_t;

    xfer_t       ro_log[$];
    xfer_t       ej_log[$];
    int          inj_fire_log[$];
    int          ring_fire_log[$];
    logic [15:0] inj_src[$];
    logic [15:0] ring_src[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit started, inj_took, ring_took;

    logic [15:0] m_inj[$];
    logic [15:0] m_pass[$];
    logic        m_ro_v, m_ej_v;
    logic [15:0] m_ro_d, m_ej_d, m_ej_cnt;
    int          m_starve;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic compare_outputs();
        check("ring_out_valid", ring_out_valid, m_ro_v);
        if (m_ro_v) check("ring_out_data", ring_out_data, m_ro_d);
        check("ej_valid", ej_valid, m_ej_v);
        if (m_ej_v) check("ej_data", ej_data, m_ej_d);
        check("ej_count", ej_count, m_ej_cnt);
        check("inj_level", inj_level, m_inj.size());
        check("inj_ready", inj_ready, !ARESET && (m_inj.size() < INJ_DEPTH));
        check("ring_in_ready", ring_in_ready, !ARESET && (m_pass.size() < PASS_DEPTH));
    endtask

    // One clock edge of the reference: 0 = no pick, 1 = pass head, 2 = inj head.
    task automatic model_step();
        bit inj_acc, pass_acc, ro_free, ej_free;
        bit p_home, p_ring, i_home, i_ring;
        int ro_pick, ej_pick;
        if (ARESET) begin
            m_inj.delete();
            m_pass.delete();
            m_ro_v = 1'b0; m_ro_d = '0;
            m_ej_v = 1'b0; m_ej_d = '0;
            m_ej_cnt = '0;
            m_starve = 0;
            return;
        end
        inj_acc  = inj_valid && (m_inj.size() < INJ_DEPTH);
        pass_acc = ring_in_valid && (m_pass.size() < PASS_DEPTH);
        ro_free  = !m_ro_v || ring_out_ready;
        ej_free  = !m_ej_v || ej_ready;
        p_home = (m_pass.size() > 0) && ((m_pass[0] >> 10) == NODE_ID);
        p_ring = (m_pass.size() > 0) && !p_home;
        i_home = (m_inj.size() > 0) && ((m_inj[0] >> 10) == NODE_ID);
        i_ring = (m_inj.size() > 0) && !i_home;
        ro_pick = 0;
        ej_pick = 0;
        if (ej_free) begin
            if (p_home) ej_pick = 1;
            else if (i_home) ej_pick = 2;
        end
        if (ro_free) begin
            if (i_ring && m_starve == STARVE_MAX) ro_pick = 2;
            else if (p_ring) ro_pick = 1;
            else if (i_ring) ro_pick = 2;
            if (!i_ring || ro_pick == 2) m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve++;
        end
        if (m_ro_v && ring_out_ready) m_ro_v = 1'b0;
        if (m_ej_v && ej_ready) m_ej_v = 1'b0;
        if (ro_pick == 1) begin m_ro_v = 1'b1; m_ro_d = m_pass.pop_front(); end
        if (ro_pick == 2) begin m_ro_v = 1'b1; m_ro_d = m_inj.pop_front(); end
        if (ej_pick == 1) begin m_ej_v = 1'b1; m_ej_d = m_pass.pop_front(); end
        if (ej_pick == 2) begin m_ej_v = 1'b1; m_ej_d = m_inj.pop_front(); end
        if (ej_pick != 0) m_ej_cnt = m_ej_cnt + 16'd1;
        if (inj_acc) m_inj.push_back(inj_data);
        if (pass_acc) m_pass.push_back(ring_in_data);
    endtask

    // Compare, log and model at the falling edge; drive sources 1 after the rising edge.
    initial begin : monitor
        inj_valid = 1'b0; inj_data = '0;
        ring_in_valid = 1'b0; ring_in_data = '0;
        started = 1'b0;
        forever begin
            @(negedge ACLK);
            if (started) compare_outputs();
            inj_took  = (inj_valid && inj_ready) === 1'b1;
            ring_took = (ring_in_valid && ring_in_ready) === 1'b1;
            if (inj_took) inj_fire_log.push_back(cyc);
            if (ring_took) ring_fire_log.push_back(cyc);
            if ((ring_out_valid && ring_out_ready) === 1'b1) ro_log.push_back(xfer_t'{cyc, ring_out_data});
            if ((ej_valid && ej_ready) === 1'b1) ej_log.push_back(xfer_t'{cyc, ej_data});
            model_step();
            if (ARESET) started = 1'b1;
            @(posedge ACLK);
            cyc++;
            #1;
            if (inj_took && inj_src.size() > 0) void'(inj_src.pop_front());
            if (ring_took && ring_src.size() > 0) void'(ring_src.pop_front());
            inj_valid     = (inj_src.size() != 0);
            inj_data      = inj_valid ? inj_src[0] : 16'h0;
            ring_in_valid = (ring_src.size() != 0);
            ring_in_data  = ring_in_valid ? ring_src[0] : 16'h0;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #2;
        end
    endtask

    task automatic clear_logs();
        ro_log.delete();
        ej_log.delete();
        inj_fire_log.delete();
        ring_fire_log.delete();
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        inj_src.delete();
        ring_src.delete();
        @(negedge ACLK);
        check("inj_ready_in_reset", inj_ready, 0);
        check("ring_in_ready_in_reset", ring_in_ready, 0);
        @(posedge ACLK);
        #2;
        ARESET = 1'b0;
        check("rst_ring_out_valid", ring_out_valid, 0);
        check("rst_ring_out_data", ring_out_data, 0);
        check("rst_ej_valid", ej_valid, 0);
        check("rst_ej_data", ej_data, 0);
        check("rst_ej_count", ej_count, 0);
        check("rst_inj_level", inj_level, 0);
        clear_logs();
    endtask

    initial begin : stim
        int n_home;
        int dest;
        ring_out_ready = 1'b0;
        ej_ready       = 1'b0;
        repeat (2) @(posedge ACLK);
        #2;
        ARESET = 1'b0;

        // Single ring-bound injection: visible on ring_out exactly two cycles later.
        do_reset();
        ring_out_ready = 1'b1; ej_ready = 1'b1;
        inj_src.push_back(16'h2123);
        run(6);
        check("t1_ro_count", ro_log.size(), 1);
        if (ro_log.size() > 0 && inj_fire_log.size() > 0) begin
            check("t1_ro_data", ro_log[0].data, 16'h2123);
            check("t1_latency", ro_log[0].cyc - inj_fire_log[0], 2);
        end
        check("t1_ej_count", ej_count, 0);

        // Ring flit for this node is ejected two cycles later.
        do_reset();
        ring_out_ready = 1'b1; ej_ready = 1'b1;
        ring_src.push_back(16'h1C55);
        run(6);
        check("t2_ej_count_log", ej_log.size(), 1);
        if (ej_log.size() > 0 && ring_fire_log.size() > 0) begin
            check("t2_ej_data", ej_log[0].data, 16'h1C55);
            check("t2_latency", ej_log[0].cyc - ring_fire_log[0], 2);
        end
        check("t2_ej_count", ej_count, 1);
        check("t2_ro_untouched", ro_log.size(), 0);

        // Starvation: eight pass flits, then the held injection, then pass again.
        do_reset();
        ring_out_ready = 1'b1; ej_ready = 1'b1;
        for (int i = 0; i < 12; i++) ring_src.push_back(16'h0C00 + 16'(i));
        inj_src.push_back(16'h0CAA);
        run(22);
        check("t3_ro_count", ro_log.size(), 13);
        if (ro_log.size() >= 10) begin
            check("t3_ro7", ro_log[7].data, 16'h0C07);
            check("t3_ro8_inj", ro_log[8].data, 16'h0CAA);
            check("t3_ro9", ro_log[9].data, 16'h0C08);
        end

        // Eject blocked: pass FIFO fills, ring-bound injection still flows.
        do_reset();
        ring_out_ready = 1'b1; ej_ready = 1'b0;
        ring_src.push_back(16'h1C10);
        ring_src.push_back(16'h1C11);
        ring_src.push_back(16'h1C12);
        inj_src.push_back(16'h0801);
        inj_src.push_back(16'h0802);
        run(8);
        check("t4_ej_valid", ej_valid, 1);
        check("t4_ej_data", ej_data, 16'h1C10);
        check("t4_ring_in_ready", ring_in_ready, 0);
        check("t4_ro_count", ro_log.size(), 2);
        if (ro_log.size() == 2) begin
            check("t4_ro0", ro_log[0].data, 16'h0801);
            check("t4_ro1", ro_log[1].data, 16'h0802);
        end
        ej_ready = 1'b1;
        run(6);
        check("t4_ej_log", ej_log.size(), 3);
        if (ej_log.size() == 3) begin
            check("t4_ej0", ej_log[0].data, 16'h1C10);
            check("t4_ej1", ej_log[1].data, 16'h1C11);
            check("t4_ej2", ej_log[2].data, 16'h1C12);
        end
        check("t4_ej_count", ej_count, 3);

        // Loopback vs ring eject in the same cycle: pass has priority.
        do_reset();
        ring_out_ready = 1'b1; ej_ready = 1'b1;
        inj_src.push_back(16'h1C01);
        ring_src.push_back(16'h1C02);
        run(6);
        check("t5_ej_log", ej_log.size(), 2);
        if (ej_log.size() == 2) begin
            check("t5_ej0", ej_log[0].data, 16'h1C02);
            check("t5_ej1", ej_log[1].data, 16'h1C01);
        end
        check("t5_ej_count", ej_count, 2);
        check("t5_ro_untouched", ro_log.size(), 0);

        // Fill the injection FIFO against a stalled ring, then reset.
        do_reset();
        ring_out_ready = 1'b0; ej_ready = 1'b1;
        for (int i = 0; i < 5; i++) inj_src.push_back(16'h0830 + 16'(i));
        run(8);
        check("t6_inj_level_full", inj_level, 4);
        check("t6_inj_ready_full", inj_ready, 0);
        check("t6_no_emit", ro_log.size(), 0);
        do_reset();
        ring_out_ready = 1'b1;
        run(6);
        check("t6_inj_level_after", inj_level, 0);
        check("t6_ro_valid_after", ring_out_valid, 0);
        check("t6_no_emit_after", ro_log.size(), 0);

        // Mixed traffic under irregular back-pressure; the model checks every cycle.
        do_reset();
        n_home = 0;
        for (int i = 0; i < 16; i++) begin
            dest = (i % 3 == 0) ? 7 : (i % 4);
            if (dest == 7) n_home++;
            inj_src.push_back({6'(dest), 10'(i + 64)});
            dest = (i % 2 == 1) ? 7 : 5;
            if (dest == 7) n_home++;
            ring_src.push_back({6'(dest), 10'(i + 256)});
        end
        for (int k = 0; k < 60; k++) begin
            ring_out_ready = (k % 3) != 2;
            ej_ready       = (k % 4) != 0;
            run(1);
        end
        ring_out_ready = 1'b1; ej_ready = 1'b1;
        run(20);
        check("t7_all_delivered", ro_log.size() + ej_log.size(), 32);
        check("t7_ej_count", ej_count, n_home);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
